// File: rtl/writeback_buffer.sv
// Small FIFO of evicted dirty cache lines drained one at a time to physical memory.
// Lines that hit a queued entry are merged in place; any valid entry can be probed by a lookup.
module writeback_buffer #(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [15:0]  in_addr,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [15:0]  lookup_addr,
   output logic         lookup_hit,
   output logic [127:0] lookup_data,
   output logic         empty
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t         r_state;
   logic [PW-1:0]  r_head;
   logic [PW-1:0]  r_tail;
   logic [CW-1:0]  r_count;
   logic [DEPTH-1:0] r_valid;
   logic [11:0]    r_tag  [DEPTH];
   logic [127:0]   r_data [DEPTH];
   logic           r_pmem_write;
   logic [15:0]    r_pmem_address;
   logic [127:0]   r_pmem_wdata;

   logic [DEPTH-1:0] w_match;
   logic [DEPTH-1:0] w_lk_match;
   logic [PW-1:0]  w_coal_idx;
   logic           w_push;
   logic           w_coal;
   logic           w_enq;
   logic           w_pop;
   logic           w_coal_head;
   logic [PW:0]    w_sum;
   logic [PW-1:0]  w_idx;
   logic           w_unused;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // The head is excluded from merging once its write is in flight, so the data sent stays coherent.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign w_match[gi]    = r_valid[gi] && (r_tag[gi] == in_addr[15:4]) &&
                                 ((PW'(gi) != r_head) || (r_state == IDLE));
         assign w_lk_match[gi] = r_valid[gi] && (r_tag[gi] == lookup_addr[15:4]);
      end
   endgenerate

   always_comb begin
      w_coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_match[i]) w_coal_idx = PW'(i);
      end
   end

   assign in_ready    = (r_count < CW'(DEPTH));
   assign empty       = (r_count == '0);
   assign w_push      = in_valid && in_ready;
   assign w_coal      = w_push && (|w_match);
   assign w_enq       = w_push && !w_coal;
   assign w_pop       = (r_state == WRITE) && pmem_resp;
   assign w_coal_head = w_coal && (w_coal_idx == r_head);
   assign w_unused    = ^{in_addr[3:0], lookup_addr[3:0]};

   // Walk from oldest to newest so the entry nearest the tail wins a duplicate match.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      w_sum       = '0;
      w_idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_sum = {1'b0, r_head} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(DEPTH)) w_sum = w_sum - (PW+1)'(DEPTH);
         w_idx = w_sum[PW-1:0];
         if (w_lk_match[w_idx]) begin
            lookup_hit  = 1'b1;
            lookup_data = r_data[w_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_valid        <= '0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= '0;
         r_pmem_wdata   <= '0;
      end else begin
         if (w_enq) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= ptr_inc(r_head);
         end
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         case (r_state)
            IDLE: begin
               if (r_count != '0) begin
                  r_state        <= WRITE;
                  r_pmem_write   <= 1'b1;
                  r_pmem_address <= {r_tag[r_head], 4'h0};
                  // A merge into the head on this same edge must reach memory too.
                  r_pmem_wdata   <= w_coal_head ? in_data : r_data[r_head];
               end
            end
            WRITE: begin
               if (pmem_resp) begin
                  r_state      <= IDLE;
                  r_pmem_write <= 1'b0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_pmem_write <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_tag[r_tail]  <= in_addr[15:4];
         r_data[r_tail] <= in_data;
      end else if (w_coal) begin
         r_data[w_coal_idx] <= in_data;
      end
   end

   assign pmem_write   = r_pmem_write;
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer (DEPTH 3): drain order, merging, fill stall,
// simultaneous push/response, head-merge forwarding and asynchronous reset abort.
module tb_writeback_buffer;

   localparam int DEPTH = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [15:0]  in_addr = '0;
   logic [127:0] in_data = '0;
   logic         in_ready;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp = 1'b0;
   logic [15:0]  lookup_addr = '0;
   logic         lookup_hit;
   logic [127:0] lookup_data;
   logic         empty;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] DAA = {16{8'hAA}};
   localparam logic [127:0] D55 = {16{8'h55}};
   localparam logic [127:0] D1  = {16{8'h11}};
   localparam logic [127:0] D2  = {16{8'h22}};
   localparam logic [127:0] D3  = {16{8'h33}};
   localparam logic [127:0] D4  = {16{8'h44}};
   localparam logic [127:0] D5  = {16{8'h5A}};
   localparam logic [127:0] D6  = {16{8'h66}};

   writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .lookup_addr  (lookup_addr),
      .lookup_hit   (lookup_hit),
      .lookup_data  (lookup_data),
      .empty        (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input logic [15:0] a, input logic hit, input logic [127:0] d);
      lookup_addr = a;
      #1;
      check({tag, "_hit"}, 128'(lookup_hit), 128'(hit));
      check({tag, "_data"}, lookup_data, d);
   endtask

   task automatic drive(input logic [15:0] a, input logic [127:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      $display("push addr %h data %h", a, d);
   endtask

   task automatic respond;
      pmem_resp = 1'b1;
      $display("pmem_resp for addr %h", pmem_address);
      tick;
      pmem_resp = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_in_ready", 128'(in_ready), 128'(1'b1));
      check("rst_empty", 128'(empty), 128'(1'b1));
      check("rst_pmem_write", 128'(pmem_write), 128'(1'b0));
      check("rst_pmem_address", 128'(pmem_address), 128'(16'h0));
      check("rst_pmem_wdata", pmem_wdata, '0);
      probe("rst_lookup", 16'h0000, 1'b0, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single line: low address bits ignored, write one edge after acceptance.
      drive(16'h1235, DAA);
      tick;
      in_valid = 1'b0;
      check("single_empty", 128'(empty), 128'(1'b0));
      check("single_wr_early", 128'(pmem_write), 128'(1'b0));
      probe("single_lookup", 16'h1230, 1'b1, DAA);
      tick;
      check("single_wr", 128'(pmem_write), 128'(1'b1));
      check("single_addr", 128'(pmem_address), 128'(16'h1230));
      check("single_data", pmem_wdata, DAA);
      respond;
      check("single_done_empty", 128'(empty), 128'(1'b1));
      check("single_done_wr", 128'(pmem_write), 128'(1'b0));
      check("resp_idle_wr", 128'(pmem_write), 128'(1'b0));

      // Fill to DEPTH, then stall.
      drive(16'h1000, D1);
      tick;
      drive(16'h2000, D2);
      tick;
      check("fill_wr", 128'(pmem_write), 128'(1'b1));
      check("fill_addr1", 128'(pmem_address), 128'(16'h1000));
      check("fill_ready2", 128'(in_ready), 128'(1'b1));
      drive(16'h4000, D4);
      tick;
      check("fill_ready_full", 128'(in_ready), 128'(1'b0));

      // Response and push on the same edge while full: push is blocked, not dropped.
      drive(16'h3000, D3);
      respond;
      check("simul_ready", 128'(in_ready), 128'(1'b1));
      check("simul_wr", 128'(pmem_write), 128'(1'b0));
      probe("simul_lk3000", 16'h3000, 1'b0, '0);
      probe("simul_lk1000", 16'h1000, 1'b0, '0);
      probe("simul_lk2000", 16'h2000, 1'b1, D2);
      tick;
      in_valid = 1'b0;
      check("order_addr2", 128'(pmem_address), 128'(16'h2000));
      check("order_data2", pmem_wdata, D2);
      check("order_ready", 128'(in_ready), 128'(1'b0));
      probe("order_lk3000", 16'h3000, 1'b1, D3);
      respond;
      tick;
      check("order_addr3", 128'(pmem_address), 128'(16'h4000));
      check("order_data3", pmem_wdata, D4);

      // Merge into a queued non-head entry.
      drive(16'h3000, D55);
      tick;
      in_valid = 1'b0;
      check("coal_ready", 128'(in_ready), 128'(1'b1));
      check("coal_stable", pmem_wdata, D4);
      probe("coal_lk3000", 16'h3000, 1'b1, D55);

      // Same address as the head being written: new entry, newest wins lookup.
      drive(16'h4000, D5);
      tick;
      in_valid = 1'b0;
      check("dup_ready", 128'(in_ready), 128'(1'b0));
      check("dup_stable", pmem_wdata, D4);
      probe("dup_lk4000", 16'h4000, 1'b1, D5);
      respond;
      tick;
      check("coal_addr", 128'(pmem_address), 128'(16'h3000));
      check("coal_data", pmem_wdata, D55);
      respond;
      check("gap_wr", 128'(pmem_write), 128'(1'b0));

      // Merge into the head during its idle cycle: forwarded into the write.
      drive(16'h4008, D6);
      tick;
      in_valid = 1'b0;
      check("hmerge_wr", 128'(pmem_write), 128'(1'b1));
      check("hmerge_addr", 128'(pmem_address), 128'(16'h4000));
      check("hmerge_data", pmem_wdata, D6);
      check("hmerge_ready", 128'(in_ready), 128'(1'b1));

      // Asynchronous reset mid-write.
      #2;
      rst_n = 1'b0;
      $display("reset asserted mid-write");
      #1;
      check("arst_wr", 128'(pmem_write), 128'(1'b0));
      check("arst_empty", 128'(empty), 128'(1'b1));
      probe("arst_lk4000", 16'h4000, 1'b0, '0);
      probe("arst_lk3000", 16'h3000, 1'b0, '0);
      tick;
      rst_n = 1'b1;
      respond;
      check("stray_wr", 128'(pmem_write), 128'(1'b0));
      check("stray_empty", 128'(empty), 128'(1'b1));
      drive(16'h5000, D1);
      tick;
      in_valid = 1'b0;
      check("post_wr_early", 128'(pmem_write), 128'(1'b0));
      tick;
      check("post_wr", 128'(pmem_write), 128'(1'b1));
      check("post_addr", 128'(pmem_address), 128'(16'h5000));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
